instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch.sv | 200 ++++++++++++++++++++
 tb/tb_instr_dispatch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
// instr_dispatch -- instruction queue feeding a single-issue dispatcher.
// Each queued opcode becomes a fetch command, a compute config, a vreg
// update, a hold, or an end marker; one command is in flight at a time.
// Optional feature: define INSTR_DISPATCH_PERF_EN to add the stall_cycles
// and issue_count saturating performance counters.
module instr_dispatch #(
  parameter  int INSTR_W    = 64,
  parameter  int FIFO_DEPTH = 8,
  parameter  int N_CH       = 4,
  localparam int CH_W       = $clog2(N_CH),
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [N_CH-1:0]    fetch_valid,
  input  logic [N_CH-1:0]    fetch_ready,
  output logic [15:0]        fetch_src,
  output logic [7:0]         fetch_dst,
  output logic [7:0]         fetch_mem_sel,
  output logic [7:0]         fetch_count,
  output logic               cfg_valid,
  input  logic               cfg_ready,
  output logic [3:0]         cfg_kernel,
  output logic [7:0]         cfg_fsize,
  output logic [2:0]         cfg_flags,
  output logic               vreg_enable,
  output logic               vreg_select,
  input  logic               resume,
  output logic               exe_done,
  output logic               illegal,
  output logic [LVL_W-1:0]   q_level
`ifdef INSTR_DISPATCH_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        issue_count
`endif
);

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_FETCH_A = 8'h02;
  localparam logic [7:0] OP_FETCH_B = 8'h04;
  localparam logic [7:0] OP_VREG    = 8'h40;
  localparam logic [7:0] OP_HOLD    = 8'h44;
  localparam logic [7:0] OP_CFG     = 8'h81;
  localparam logic [7:0] OP_END     = 8'h82;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_F, WAIT_C, HOLD, DONE} state_t;

  state_t             state, state_nx;
  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               full, push, pop;
  logic [CH_W-1:0]    ch_q;

  assign full        = (count == LVL_W'(FIFO_DEPTH));
  assign pop         = (state == ISSUE);
  // A pop in the same cycle frees a slot, so a full queue may still accept.
  assign instr_ready = !full || pop;
  assign push        = instr_valid && instr_ready;
  assign q_level     = count;

  // Head decode: opcode in the top byte, F1..F7 in the byte lanes below.
  logic [INSTR_W-1:0] head;
  logic [7:0]         opcode, f1, f2, f3, f4, f5, f6, f7;
  logic               is_fetch, is_bad, unused_bits;

  assign head     = mem[rd_ptr];
  assign opcode   = head[INSTR_W-1  -: 8];
  assign f1       = head[INSTR_W-9  -: 8];
  assign f2       = head[INSTR_W-17 -: 8];
  assign f3       = head[INSTR_W-25 -: 8];
  assign f4       = head[INSTR_W-33 -: 8];
  assign f5       = head[INSTR_W-41 -: 8];
  assign f6       = head[INSTR_W-49 -: 8];
  assign f7       = head[INSTR_W-57 -: 8];
  assign is_fetch = (opcode == OP_FETCH_A) || (opcode == OP_FETCH_B);
  assign is_bad   = !(opcode inside {OP_NOP, OP_FETCH_A, OP_FETCH_B, OP_VREG,
                                     OP_HOLD, OP_CFG, OP_END});
  assign unused_bits = ^{head, f1, f4, f5, f6};

  // Queue storage, written on every accepted push.
  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale entries are never read as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr_in;
  end

  // Queue pointers and occupancy; pointers wrap since depth is a power of two.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state: pick the wait state from the head opcode, leave on handshake.
  // NOTE: state_nx gets a default before the case so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (count != '0) state_nx = ISSUE;
      ISSUE: begin
        if (is_fetch)                 state_nx = WAIT_F;
        else if (opcode == OP_CFG)    state_nx = WAIT_C;
        else if (opcode == OP_HOLD)   state_nx = HOLD;
        else if (opcode == OP_END)    state_nx = DONE;
        else                          state_nx = IDLE;
      end
      WAIT_F: if (fetch_ready[ch_q]) state_nx = IDLE;
      WAIT_C: if (cfg_ready)         state_nx = IDLE;
      HOLD:   if (resume)            state_nx = IDLE;
      DONE:                          state_nx = DONE;
      default:                       state_nx = IDLE;
    endcase
  end

  // FSM outputs: handshake valids follow directly from the wait states.
  always_comb begin
    fetch_valid = '0;
    cfg_valid   = 1'b0;
    if (state == WAIT_F) fetch_valid[ch_q] = 1'b1;
    if (state == WAIT_C) cfg_valid = 1'b1;
  end

  // Command fields and side-effect flags, captured as the head is issued;
  // they stay stable for the whole time the matching valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q          <= '0;
      fetch_src     <= '0;
      fetch_dst     <= '0;
      fetch_mem_sel <= '0;
      fetch_count   <= '0;
      cfg_kernel    <= '0;
      cfg_fsize     <= '0;
      cfg_flags     <= '0;
      vreg_enable   <= 1'b0;
      vreg_select   <= 1'b0;
      exe_done      <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      illegal <= pop && is_bad;
      if (pop) begin
        if (is_fetch) begin
          ch_q          <= f1[CH_W-1:0];
          fetch_src     <= {f2, f3};
          fetch_dst     <= {f4[3:0], f5[3:0]};
          fetch_mem_sel <= f6;
          fetch_count   <= f7;
        end
        if (opcode == OP_CFG) begin
          cfg_kernel <= f3[3:0];
          cfg_fsize  <= f2;
          cfg_flags  <= {f6[0], f4[0], f1[0]};
        end
        if (opcode == OP_VREG) begin
          vreg_enable <= f1[0];
          vreg_select <= f2[0];
        end
        if (opcode == OP_END) exe_done <= 1'b1;
      end
    end
  end

`ifdef INSTR_DISPATCH_PERF_EN
  logic stalled;
  assign stalled = state inside {WAIT_F, WAIT_C, HOLD};

  // Saturating stall-cycle and issued-instruction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (stalled && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (pop && issue_count != '1)      issue_count  <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch -- directed scenarios followed by a randomized run
// scored against a queue-level reference model of the dispatcher.
module tb_instr_dispatch;
  localparam int INSTR_W    = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int N_CH       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  fetch_valid;
  logic [3:0]  fetch_ready = '0;
  logic [15:0] fetch_src;
  logic [7:0]  fetch_dst, fetch_mem_sel, fetch_count;
  logic        cfg_valid;
  logic        cfg_ready = 1'b0;
  logic [3:0]  cfg_kernel;
  logic [7:0]  cfg_fsize;
  logic [2:0]  cfg_flags;
  logic        vreg_enable, vreg_select;
  logic        resume = 1'b0;
  logic        exe_done, illegal;
  logic [3:0]  q_level;

  int n_checks = 0;
  int n_errors = 0;
  int ill_seen = 0;

  // Reference model state: queue of accepted instructions plus side effects.
  logic [63:0] mq[$];
  int          exp_ill;
  logic        exp_ven, exp_vsel;

  instr_dispatch #(.INSTR_W(INSTR_W), .FIFO_DEPTH(FIFO_DEPTH), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_src(fetch_src), .fetch_dst(fetch_dst), .fetch_mem_sel(fetch_mem_sel),
    .fetch_count(fetch_count), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel(cfg_kernel), .cfg_fsize(cfg_fsize), .cfg_flags(cfg_flags),
    .vreg_enable(vreg_enable), .vreg_select(vreg_select), .resume(resume),
    .exe_done(exe_done), .illegal(illegal), .q_level(q_level)
  );

  always #5 clk = ~clk;

  // Cycles with illegal high, sampled mid-cycle.
  always @(negedge clk) if (illegal === 1'b1) ill_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] lane(input logic [63:0] w, input int k);
    return 8'(w >> (56 - 8 * k));
  endfunction

  function automatic bit issues(input logic [63:0] w);
    return lane(w, 0) inside {8'h02, 8'h04, 8'h81};
  endfunction

  // Effect of an entry that produces no handshake (vreg write or bad opcode).
  task automatic apply(input logic [63:0] w);
    if (lane(w, 0) == 8'h40) begin
      exp_ven  = 1'(lane(w, 1));
      exp_vsel = 1'(lane(w, 2));
    end else if (lane(w, 0) != 8'h00) begin
      exp_ill++;
    end
  endtask

  // Compare the visible command against what instruction w should produce.
  task automatic cmp_cmd(input string tag, input logic [63:0] w);
    if (lane(w, 0) == 8'h81)
      check(tag, {cfg_valid, fetch_valid, cfg_kernel, cfg_fsize, cfg_flags},
            {1'b1, 4'b0000, 4'(lane(w, 3)), lane(w, 2),
             1'(lane(w, 6)), 1'(lane(w, 4)), 1'(lane(w, 1))});
    else
      check(tag, {cfg_valid, fetch_valid, fetch_src, fetch_dst, fetch_mem_sel, fetch_count},
            {1'b0, 4'(1 << (lane(w, 1) % N_CH)), lane(w, 2), lane(w, 3),
             4'(lane(w, 4)), 4'(lane(w, 5)), lane(w, 6), lane(w, 7)});
  endtask

  function automatic logic [63:0] rand_instr();
    logic [63:0] w;
    logic [7:0]  op;
    int          sel;
    w   = {$urandom, $urandom};
    sel = $urandom_range(0, 9);
    if (sel < 4)       op = sel[0] ? 8'h02 : 8'h04;
    else if (sel < 6)  op = 8'h81;
    else if (sel < 8)  op = 8'h40;
    else if (sel == 8) op = 8'h00;
    else begin
      op = 8'($urandom);
      if (op inside {8'h00, 8'h02, 8'h04, 8'h40, 8'h44, 8'h81, 8'h82}) op = 8'h01;
    end
    w[63:56] = op;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; fetch_ready = '0; cfg_ready = 1'b0; resume = 1'b0;
    step(2);
    rst = 1'b0;
    step();
  endtask

  task automatic push(input logic [63:0] w);
    int budget = 50;
    while (!instr_ready && budget > 0) begin step(); budget--; end
    check("push_ready", instr_ready, 1'b1);
    instr_in = w; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_fetch(output int cyc);
    cyc = 0;
    while (fetch_valid == '0 && cyc < 40) begin step(); cyc++; end
  endtask

  initial begin
    int          cyc, hi, got, ill_base, left;
    bit          valid_now, prev_valid, prev_ready;
    logic [63:0] cur, w;

    // Reset state.
    do_reset();
    check("rst_ready", instr_ready, 1'b1);
    check("rst_level", q_level, 0);
    check("rst_outputs", {fetch_valid, cfg_valid, exe_done, illegal, vreg_enable, vreg_select},
          10'b0);
    check("rst_data", {fetch_src, fetch_dst, fetch_mem_sel, fetch_count,
                       cfg_kernel, cfg_fsize, cfg_flags}, 63'b0);

    // Single fetch with the channel already ready: two-cycle latency, one-cycle valid.
    fetch_ready = 4'b0010;
    push(64'h0205_1234_0102_0308);
    wait_fetch(cyc);
    check("fetch_latency", cyc, 2);
    check("fetch_vec", fetch_valid, 4'b0010);
    check("fetch_fields", {fetch_src, fetch_dst, fetch_mem_sel, fetch_count}, 40'h1234_12_03_08);
    step();
    check("fetch_one_cycle", fetch_valid, 4'b0000);
    fetch_ready = '0;
    step(2);

    // Back-pressure: nine fetches on channel 2, queue fills behind the first.
    for (int i = 0; i < 9; i++) push(64'h0202_0000_0000_0000 | (64'(16'h1000 + i) << 32));
    check("full_ready_low", instr_ready, 1'b0);
    check("full_level", q_level, 8);
    check("full_head_src", fetch_src, 16'h1000);
    fetch_ready = 4'b0100;
    cyc = 0;
    while (!instr_ready && cyc < 20) begin step(); cyc++; end
    check("ready_rises", instr_ready, 1'b1);
    check("full_pop_level", q_level, 8);
    instr_in = 64'h0202_1009_0000_0000; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("full_push_pop_level", q_level, 8);
    got = 0;
    for (int g = 0; g < 200 && got < 9; g++) begin
      if (fetch_valid != '0) begin
        check("inorder_src", fetch_src, 16'h1001 + got);
        got++;
      end
      step();
    end
    check("inorder_count", got, 9);
    step(3);
    check("drain_level", q_level, 0);
    fetch_ready = '0;

    // Config with cfg_ready held low for five cycles of valid.
    push(64'h8101_1C03_0100_0100);
    cyc = 0;
    while (!cfg_valid && cyc < 40) begin step(); cyc++; end
    check("cfg_latency", cyc, 2);
    check("cfg_fields", {cfg_kernel, cfg_fsize, cfg_flags}, {4'h3, 8'h1C, 3'b111});
    hi = 0;
    for (int g = 0; g < 30; g++) begin
      if (cfg_valid) hi++;
      else if (hi > 0) break;
      cfg_ready = (hi >= 6);
      step();
    end
    check("cfg_valid_cycles", hi, 6);
    cfg_ready = 1'b0;

    // Hold then vreg: resume outside HOLD is ignored, vreg waits for resume.
    resume = 1'b1; step(); resume = 1'b0;
    push(64'h4400_0000_0000_0000);
    push(64'h4001_0100_0000_0000);
    step(8);
    check("hold_vreg", {vreg_enable, vreg_select}, 2'b00);
    check("hold_level", q_level, 1);
    resume = 1'b1; step(); resume = 1'b0;
    step(4);
    check("resume_vreg", {vreg_enable, vreg_select}, 2'b11);
    check("resume_level", q_level, 0);

    // Bad opcodes then end marker; DONE queues but never issues.
    ill_base = ill_seen;
    push(64'h0000_0000_0000_0000);
    push(64'h7F00_0000_0000_0000);
    push(64'h0100_0000_0000_0000);
    push(64'h8200_0000_0000_0000);
    step(12);
    check("illegal_pulses", ill_seen - ill_base, 2);
    check("done_flag", exe_done, 1'b1);
    fetch_ready = '1;
    push(64'h0201_5555_0000_0000);
    hi = 0;
    for (int g = 0; g < 10; g++) begin
      if (fetch_valid != '0) hi++;
      step();
    end
    check("done_no_issue", hi, 0);
    check("done_level", q_level, 1);
    check("done_sticky", exe_done, 1'b1);
    do_reset();
    check("done_rst", {exe_done, illegal, vreg_enable, vreg_select, q_level}, 8'b0);

    // Reset in the middle of a fetch handshake drops the command.
    push(64'h0201_AAAA_0000_0000);
    push(64'h0201_BBBB_0000_0000);
    wait_fetch(cyc);
    check("mid_valid", fetch_valid, 4'b0010);
    check("mid_level", q_level, 1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", fetch_valid, 4'b0000);
    check("mid_rst_level", q_level, 0);
    rst = 1'b0;
    step();
    fetch_ready = 4'b0010;
    push(64'h0201_CCCC_0000_0000);
    wait_fetch(cyc);
    check("post_rst_latency", cyc, 2);
    check("post_rst_src", fetch_src, 16'hCCCC);
    do_reset();

    // Randomized traffic scored against the queue-level model.
    mq.delete();
    exp_ill = 0; exp_ven = 1'b0; exp_vsel = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; cur = '0;
    ill_base = ill_seen;
    for (int c = 0; c < 1600; c++) begin
      valid_now = (fetch_valid != '0) || cfg_valid;
      if (prev_valid) begin
        if (prev_ready) check("rnd_release", valid_now, 1'b0);
        else begin
          check("rnd_hold", valid_now, 1'b1);
          cmp_cmd("rnd_stable", cur);
        end
      end else if (valid_now) begin
        while (mq.size() > 0 && !issues(mq[0])) apply(mq.pop_front());
        check("rnd_cmd_queued", mq.size() > 0, 1'b1);
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          cmp_cmd("rnd_cmd", cur);
          check("rnd_vreg", {vreg_enable, vreg_select}, {exp_ven, exp_vsel});
        end
      end
      if (c < 1500) begin
        fetch_ready = 4'($urandom);
        cfg_ready   = 1'($urandom);
      end else begin
        fetch_ready = '1;
        cfg_ready   = 1'b1;
      end
      prev_ready = ((fetch_valid & fetch_ready) != '0) || (cfg_valid && cfg_ready);
      prev_valid = valid_now;
      if (c < 1500 && $urandom_range(0, 9) < 6) begin
        instr_in = rand_instr(); instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      if (instr_valid && instr_ready) mq.push_back(instr_in);
      step();
    end
    instr_valid = 1'b0;
    left = 0;
    while (mq.size() > 0) begin
      w = mq.pop_front();
      if (issues(w)) left++;
      else apply(w);
    end
    check("rnd_unissued", left, 0);
    check("rnd_illegal_count", ill_seen - ill_base, exp_ill);
    check("rnd_vreg_final", {vreg_enable, vreg_select}, {exp_ven, exp_vsel});
    check("rnd_level", q_level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
